// File: rtl/rv32_alu_issue_pkg.sv
// Shared definitions for the RV32I ALU issue slice: ALU operation codes,
// base opcodes, the issue payload and immediate helpers.
package rv32_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPSEL_W = 5;

  typedef enum logic [OPSEL_W-1:0] {
    ALU_ADD       = 5'd0,
    ALU_SUB       = 5'd1,
    ALU_SLL       = 5'd2,
    ALU_SLT       = 5'd3,
    ALU_SLTU      = 5'd4,
    ALU_XOR       = 5'd5,
    ALU_SRL       = 5'd6,
    ALU_AUIPC     = 5'd7,
    ALU_BRCMP     = 5'd8,
    ALU_SRA       = 5'd9,
    ALU_OR        = 5'd10,
    ALU_AND       = 5'd11,
    ALU_LUI       = 5'd12,
    ALU_LOADADDR  = 5'd15,
    ALU_STOREADDR = 5'd16,
    ALU_JUMP      = 5'd17
  } alu_opsel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_opsel_e        opsel;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   pc;
    logic              illegal;
  } issue_payload_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // funct3 to ALU op for OP/OP-IMM; alt selects SUB/SRA where applicable
  function automatic alu_opsel_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_opsel_e op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu_issue_decode.sv
// Combinational RV32I decode: instruction, PC and forwarded register values
// into the ALU issue payload (opsel, operands, carried data, illegal flag).
module rv32_alu_issue_decode
  import rv32_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  logic [31:0]    pc_i,
  input  logic [31:0]    rs1_i,
  input  logic [31:0]    rs2_i,
  output issue_payload_t payload_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            is_shift_imm;
  alu_opsel_e      opsel;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            illegal;

  assign opcode       = instr_i[6:0];
  assign f3           = instr_i[14:12];
  assign f7           = instr_i[31:25];
  assign is_shift_imm = (f3 == 3'b001) || (f3 == 3'b101);

  // Opcode/funct decode and operand selection; illegal forces ADD 0,0
  always_comb begin
    opsel   = ALU_ADD;
    opa     = '0;
    opb     = '0;
    illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        opa   = rs1_i;
        opb   = rs2_i;
        opsel = alu_from_funct3(f3, f7 == F7_ALT);
        if (!((f7 == F7_BASE) ||
              ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        opa = rs1_i;
        if (is_shift_imm) begin
          opb   = {27'd0, instr_i[24:20]};
          opsel = alu_from_funct3(f3, (f3 == 3'b101) && (f7 == F7_ALT));
          if (f3 == 3'b001) illegal = (f7 != F7_BASE);
          else              illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end else begin
          opb   = imm_i(instr_i);
          opsel = alu_from_funct3(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        opb   = imm_u(instr_i);
        opsel = ALU_LUI;
      end
      OPC_AUIPC: begin
        opa   = pc_i;
        opb   = imm_u(instr_i);
        opsel = ALU_AUIPC;
      end
      OPC_BRANCH: begin
        opa   = rs1_i;
        opb   = rs2_i;
        opsel = ALU_BRCMP;
      end
      OPC_LOAD: begin
        opa   = rs1_i;
        opb   = imm_i(instr_i);
        opsel = ALU_LOADADDR;
      end
      OPC_STORE: begin
        opa   = rs1_i;
        opb   = imm_s(instr_i);
        opsel = ALU_STOREADDR;
      end
      OPC_JAL: begin
        opa   = pc_i;
        opb   = imm_j(instr_i);
        opsel = ALU_JUMP;
      end
      OPC_JALR: begin
        opa   = rs1_i;
        opb   = imm_i(instr_i);
        opsel = ALU_JUMP;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      opsel = ALU_ADD;
      opa   = '0;
      opb   = '0;
    end
  end

  assign payload_o = '{opsel:    opsel,
                       opa:      opa,
                       opb:      opb,
                       rs2_data: rs2_i,
                       pc:       pc_i,
                       illegal:  illegal};

endmodule

// File: rtl/rv32_alu_issue.sv
// RV32I ALU issue stage: decodes one instruction per input handshake and
// presents a registered payload to EX with valid/ready, stall and flush.
// Optional macro RV32_ISSUE_SKID_EN adds a one-entry skid buffer so that
// in_ready is registered and independent of out_ready.
module rv32_alu_issue
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPSEL_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPSEL_W-1:0] alu_opsel,
  output logic [XLEN-1:0]    opA,
  output logic [XLEN-1:0]    opB,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_illegal
);

  issue_payload_t dec;
  issue_payload_t out_q;
  logic           out_valid_q;

  rv32_alu_issue_decode u_decode (
    .instr_i   (in_instr),
    .pc_i      (in_pc),
    .rs1_i     (in_rs1_data),
    .rs2_i     (in_rs2_data),
    .payload_o (dec)
  );

`ifdef RV32_ISSUE_SKID_EN
  issue_payload_t skid_q;
  logic           skid_valid_q;

  assign in_ready = !skid_valid_q;

  // Output slot plus skid entry; skid always drains first to keep order
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Single output register: load on accept, empty on drain without refill
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid    = out_valid_q;
  assign alu_opsel    = out_q.opsel;
  assign opA          = out_q.opa;
  assign opB          = out_q.opb;
  assign out_rs2_data = out_q.rs2_data;
  assign out_pc       = out_q.pc;
  assign out_illegal  = out_q.illegal;

endmodule
